// File: rtl/alu_ctrl_pkg.sv
// Shared types and encodings for the ALU/data-memory control sequencer.
// Holds the state enum, opcode/funct values, ALUcontrol codes and error codes.
package alu_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_DECODE    = 4'd1,
    S_EXEC_R    = 4'd2,
    S_EXEC_ADDR = 4'd3,
    S_MEM_RD    = 4'd4,
    S_MEM_WR    = 4'd5,
    S_WB_R      = 4'd6,
    S_WB_MEM    = 4'd7,
    S_EXEC_BR   = 4'd8,
    S_RETIRE    = 4'd9,
    S_FAULT     = 4'd10
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

endpackage

// File: rtl/alu_funct_dec.sv
// Combinational R-type funct decoder: funct -> ALUcontrol plus a legal flag.
// Unknown funct codes report legal=0 and ALUcontrol=AND.
module alu_funct_dec
  import alu_ctrl_pkg::*;
(
  input  logic [5:0] i_funct,
  output logic [3:0] o_alu_ctrl,
  output logic       o_legal
);

  always_comb begin
    o_alu_ctrl = ALU_AND;
    o_legal    = 1'b1;
    case (i_funct)
      FN_ADD:  o_alu_ctrl = ALU_ADD;
      FN_SUB:  o_alu_ctrl = ALU_SUB;
      FN_AND:  o_alu_ctrl = ALU_AND;
      FN_OR:   o_alu_ctrl = ALU_OR;
      FN_SLT:  o_alu_ctrl = ALU_SLT;
      default: o_legal    = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_fsm.sv
// Multi-cycle control sequencer for the ALU and data memory (valid/ready in, Moore strobes out).
// Define ALU_CTRL_BNE_EN to decode bne (op 05) as a branch taken on ~zero.
//  state     | meaning
//  IDLE      | ready for an instruction, latch on valid
//  DECODE    | classify latched opcode/funct
//  EXEC_R    | R-type ALU operation
//  EXEC_ADDR | address / immediate add (lw, sw, addi)
//  MEM_RD    | wait for load completion, with timeout
//  MEM_WR    | wait for store completion, with timeout
//  WB_R      | ALU result write-back, retire
//  WB_MEM    | load data write-back, retire
//  EXEC_BR   | branch compare, retire
//  RETIRE    | store completion, retire
//  FAULT     | illegal or timed-out instruction, retire with error
module alu_ctrl_fsm
  import alu_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int TMO_W       = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_instr_valid,
  output logic        o_instr_ready,
  input  logic [31:0] i_instr,
  input  logic        i_zero,
  input  logic        i_mem_ready,
  output logic [3:0]  o_alu_control,
  output logic        o_alusrc_b,
  output logic        o_reg_write,
  output logic        o_mem_to_reg,
  output logic        o_mem_read,
  output logic        o_mem_write,
  output logic        o_branch,
  output logic        o_br_taken,
  output logic        o_done,
  output logic [1:0]  o_err
);

  localparam logic [TMO_W-1:0] LP_CNT_LAST = TMO_W'(MEM_TIMEOUT - 1);

  state_e           r_state;
  logic [31:0]      r_instr;
  logic [TMO_W-1:0] r_cnt;
  logic             r_tmo;

  logic [5:0] w_op;
  logic [3:0] w_fn_alu;
  logic       w_fn_legal;
  logic       w_is_br;
  logic       w_br_cond;
  logic       w_unused;

  assign w_op     = r_instr[31:26];
  assign w_unused = ^r_instr[25:6];

  alu_funct_dec u_funct_dec (
    .i_funct    (r_instr[5:0]),
    .o_alu_ctrl (w_fn_alu),
    .o_legal    (w_fn_legal)
  );

`ifdef ALU_CTRL_BNE_EN
  assign w_is_br   = (w_op == OP_BEQ) || (w_op == OP_BNE);
  assign w_br_cond = (w_op == OP_BNE) ? ~i_zero : i_zero;
`else
  assign w_is_br   = (w_op == OP_BEQ);
  assign w_br_cond = i_zero;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_instr <= '0;
      r_cnt   <= '0;
      r_tmo   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_instr_valid) begin
            r_instr <= i_instr;
            r_tmo   <= 1'b0;
            r_state <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (w_op == OP_RTYPE && w_fn_legal)
            r_state <= S_EXEC_R;
          else if (w_op == OP_LW || w_op == OP_SW || w_op == OP_ADDI)
            r_state <= S_EXEC_ADDR;
          else if (w_is_br)
            r_state <= S_EXEC_BR;
          else
            r_state <= S_FAULT;
        end
        S_EXEC_R: r_state <= S_WB_R;
        S_EXEC_ADDR: begin
          r_cnt <= '0;
          if (w_op == OP_LW)
            r_state <= S_MEM_RD;
          else if (w_op == OP_SW)
            r_state <= S_MEM_WR;
          else
            r_state <= S_WB_R;
        end
        S_MEM_RD, S_MEM_WR: begin
          r_cnt <= r_cnt + 1'b1;
          // completion takes priority over expiry in the same cycle
          if (i_mem_ready) begin
            r_state <= (r_state == S_MEM_RD) ? S_WB_MEM : S_RETIRE;
          end else if (r_cnt == LP_CNT_LAST) begin
            r_tmo   <= 1'b1;
            r_state <= S_FAULT;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    o_instr_ready = 1'b0;
    o_alu_control = ALU_AND;
    o_alusrc_b    = 1'b0;
    o_reg_write   = 1'b0;
    o_mem_to_reg  = 1'b0;
    o_mem_read    = 1'b0;
    o_mem_write   = 1'b0;
    o_branch      = 1'b0;
    o_br_taken    = 1'b0;
    o_done        = 1'b0;
    o_err         = ERR_OK;
    case (r_state)
      S_IDLE:   o_instr_ready = 1'b1;
      S_EXEC_R: o_alu_control = w_fn_alu;
      S_EXEC_ADDR: begin
        o_alu_control = ALU_ADD;
        o_alusrc_b    = 1'b1;
      end
      S_MEM_RD: begin
        o_alu_control = ALU_ADD;
        o_alusrc_b    = 1'b1;
        o_mem_read    = 1'b1;
      end
      S_MEM_WR: begin
        o_alu_control = ALU_ADD;
        o_alusrc_b    = 1'b1;
        o_mem_write   = 1'b1;
      end
      S_WB_R: begin
        o_alu_control = (w_op == OP_ADDI) ? ALU_ADD : w_fn_alu;
        o_alusrc_b    = (w_op == OP_ADDI);
        o_reg_write   = 1'b1;
        o_done        = 1'b1;
      end
      S_WB_MEM: begin
        o_reg_write  = 1'b1;
        o_mem_to_reg = 1'b1;
        o_done       = 1'b1;
      end
      S_EXEC_BR: begin
        o_alu_control = ALU_SUB;
        o_branch      = 1'b1;
        o_br_taken    = w_br_cond;
        o_done        = 1'b1;
      end
      S_RETIRE: o_done = 1'b1;
      S_FAULT: begin
        o_done = 1'b1;
        o_err  = r_tmo ? ERR_TIMEOUT : ERR_ILLEGAL;
      end
      default: o_instr_ready = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_alu_ctrl_fsm.sv
// Self-checking bench for alu_ctrl_fsm: directed vector table, reset/hold sequences,
// and randomized instructions scored against a per-instruction summary model.
module tb_alu_ctrl_fsm;

  localparam int TMO = 15;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_instr_valid = 1'b0;
  logic [31:0] i_instr = '0;
  logic        i_zero = 1'b0;
  logic        i_mem_ready = 1'b0;
  logic        o_instr_ready;
  logic [3:0]  o_alu_control;
  logic        o_alusrc_b, o_reg_write, o_mem_to_reg, o_mem_read, o_mem_write;
  logic        o_branch, o_br_taken, o_done;
  logic [1:0]  o_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 i_clk = ~i_clk;

  alu_ctrl_fsm #(.MEM_TIMEOUT(TMO), .TMO_W(4)) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_instr_valid (i_instr_valid),
    .o_instr_ready (o_instr_ready),
    .i_instr       (i_instr),
    .i_zero        (i_zero),
    .i_mem_ready   (i_mem_ready),
    .o_alu_control (o_alu_control),
    .o_alusrc_b    (o_alusrc_b),
    .o_reg_write   (o_reg_write),
    .o_mem_to_reg  (o_mem_to_reg),
    .o_mem_read    (o_mem_read),
    .o_mem_write   (o_mem_write),
    .o_branch      (o_branch),
    .o_br_taken    (o_br_taken),
    .o_done        (o_done),
    .o_err         (o_err)
  );

  // Per-instruction summary: how long it took, how it ended, how many cycles each strobe was up.
  typedef struct {
    int lat;
    int err;
    int n_ready;
    int n_rw;
    int n_m2r;
    int n_mr;
    int n_mw;
    int n_branch;
    int n_br;
    int alu3;
    int timed_out;
  } obs_t;

  typedef struct {
    logic [31:0] instr;
    logic        z;
    int          waitn;
    int          e_lat;
    int          e_err;
    int          e_alu;
    int          e_br;
  } vec_t;

  vec_t tbl[$];

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int alu_of_funct(input logic [5:0] fn);
    case (fn)
      6'h20: return 2;
      6'h22: return 6;
      6'h24: return 0;
      6'h25: return 1;
      6'h2A: return 7;
      default: return -1;
    endcase
  endfunction

  function automatic obs_t model(input logic [31:0] ins, input logic z, input int waitn);
    obs_t m;
    logic [5:0] op;
    bit illegal;
    m = '{default: 0};
    m.n_ready = 1;
    op = ins[31:26];
    illegal = 1'b0;
    case (op)
      6'h00: begin
        if (alu_of_funct(ins[5:0]) < 0) illegal = 1'b1;
        else begin m.lat = 4; m.n_rw = 1; m.alu3 = alu_of_funct(ins[5:0]); end
      end
      6'h08: begin m.lat = 4; m.n_rw = 1; m.alu3 = 2; end
      6'h23, 6'h2B: begin
        m.alu3 = 2;
        if (waitn < TMO) begin
          m.lat = 5 + waitn;
          if (op == 6'h23) begin m.n_mr = waitn + 1; m.n_rw = 1; m.n_m2r = 1; end
          else m.n_mw = waitn + 1;
        end else begin
          m.lat = 4 + TMO;
          m.err = 2;
          if (op == 6'h23) m.n_mr = TMO; else m.n_mw = TMO;
        end
      end
      6'h04: begin m.lat = 3; m.n_branch = 1; m.alu3 = 6; m.n_br = int'(z); end
`ifdef ALU_CTRL_BNE_EN
      6'h05: begin m.lat = 3; m.n_branch = 1; m.alu3 = 6; m.n_br = int'(!z); end
`endif
      default: illegal = 1'b1;
    endcase
    if (illegal) begin m.lat = 3; m.err = 1; m.alu3 = 0; end
    return m;
  endfunction

  // Presents one instruction in IDLE, answers memory requests after waitn cycles,
  // and records what the DUT did until done (or a cycle budget runs out).
  task automatic run_instr(input logic [31:0] ins, input logic z, input int waitn,
                           input bit hold, output obs_t o);
    int cyc;
    int memidx;
    bit got;
    o = '{default: 0};
    i_zero = z;
    i_instr = ins;
    i_instr_valid = 1'b1;
    i_mem_ready = 1'b0;
    cyc = 1;
    memidx = 0;
    got = 1'b0;
    while (!got && cyc < 60) begin
      if (o_instr_ready) o.n_ready++;
      if (o_reg_write)   o.n_rw++;
      if (o_mem_to_reg)  o.n_m2r++;
      if (o_mem_read)    o.n_mr++;
      if (o_mem_write)   o.n_mw++;
      if (o_branch)      o.n_branch++;
      if (o_br_taken)    o.n_br++;
      if (cyc == 3)      o.alu3 = int'(o_alu_control);
      if (o_mem_read || o_mem_write) begin
        i_mem_ready = (memidx == waitn);
        memidx++;
      end else begin
        i_mem_ready = 1'b0;
      end
      if (o_done) begin
        got = 1'b1;
        o.lat = cyc;
        o.err = int'(o_err);
      end
      step();
      cyc++;
      if (hold && !got) begin
        i_instr_valid = 1'b1;
        i_instr = $urandom;
      end else begin
        i_instr_valid = 1'b0;
      end
    end
    i_mem_ready = 1'b0;
    o.timed_out = got ? 0 : 1;
  endtask

  task automatic run_and_score(input string tag, input logic [31:0] ins, input logic z,
                               input int waitn, input bit hold, output obs_t o);
    obs_t m;
    run_instr(ins, z, waitn, hold, o);
    m = model(ins, z, waitn);
    chk({tag, " done_seen"}, o.timed_out, 0);
    chk({tag, " latency"}, o.lat, m.lat);
    chk({tag, " err"}, o.err, m.err);
    chk({tag, " ready_cycles"}, o.n_ready, m.n_ready);
    chk({tag, " regwrite_cycles"}, o.n_rw, m.n_rw);
    chk({tag, " memtoreg_cycles"}, o.n_m2r, m.n_m2r);
    chk({tag, " memread_cycles"}, o.n_mr, m.n_mr);
    chk({tag, " memwrite_cycles"}, o.n_mw, m.n_mw);
    chk({tag, " branch_cycles"}, o.n_branch, m.n_branch);
    chk({tag, " br_taken_cycles"}, o.n_br, m.n_br);
    chk({tag, " alu_cycle3"}, o.alu3, m.alu3);
    chk({tag, " ready_after_done"}, int'(o_instr_ready), 1);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins;
    logic [5:0] fns [6];
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h21};
    ins = $urandom;
    case ($urandom_range(0, 7))
      0, 1: begin ins[31:26] = 6'h00; ins[5:0] = fns[$urandom_range(0, 5)]; end
      2: ins[31:26] = 6'h08;
      3: ins[31:26] = 6'h23;
      4: ins[31:26] = 6'h2B;
      5: ins[31:26] = 6'h04;
      6: ins[31:26] = 6'h05;
      default: ins[31:26] = 6'($urandom_range(0, 63));
    endcase
    return ins;
  endfunction

  initial begin
    obs_t o;
    int n_done;

    tbl.push_back('{32'h00221820, 1'b0, 0,  4, 0, 2, 0});
    tbl.push_back('{32'h00221822, 1'b1, 0,  4, 0, 6, 0});
    tbl.push_back('{32'h00221824, 1'b0, 0,  4, 0, 0, 0});
    tbl.push_back('{32'h00221825, 1'b0, 0,  4, 0, 1, 0});
    tbl.push_back('{32'h0022182A, 1'b0, 0,  4, 0, 7, 0});
    tbl.push_back('{32'h20410005, 1'b0, 0,  4, 0, 2, 0});
    tbl.push_back('{32'h8C410004, 1'b0, 3,  8, 0, 2, 0});
    tbl.push_back('{32'h8C410004, 1'b0, 14, 19, 0, 2, 0});
    tbl.push_back('{32'hAC410004, 1'b0, 0,  5, 0, 2, 0});
    tbl.push_back('{32'hAC410004, 1'b0, 99, 19, 2, 2, 0});
    tbl.push_back('{32'h10220003, 1'b1, 0,  3, 0, 6, 1});
    tbl.push_back('{32'h10220003, 1'b0, 0,  3, 0, 6, 0});
    tbl.push_back('{32'h00221821, 1'b0, 0,  3, 1, 0, 0});
    tbl.push_back('{32'hFC000000, 1'b1, 0,  3, 1, 0, 0});
`ifdef ALU_CTRL_BNE_EN
    tbl.push_back('{32'h14220003, 1'b1, 0,  3, 0, 6, 0});
    tbl.push_back('{32'h14220003, 1'b0, 0,  3, 0, 6, 1});
`else
    tbl.push_back('{32'h14220003, 1'b1, 0,  3, 1, 0, 0});
    tbl.push_back('{32'h14220003, 1'b0, 0,  3, 1, 0, 0});
`endif

    step();
    step();
    chk("reset ready", int'(o_instr_ready), 1);
    chk("reset done", int'(o_done), 0);
    chk("reset err", int'(o_err), 0);
    chk("reset alu", int'(o_alu_control), 0);
    chk("reset strobes", int'({o_alusrc_b, o_reg_write, o_mem_to_reg, o_mem_read,
                               o_mem_write, o_branch, o_br_taken}), 0);
    i_rst = 1'b0;
    step();

    foreach (tbl[k]) begin
      string tag;
      tag = $sformatf("vec%0d", k);
      run_and_score(tag, tbl[k].instr, tbl[k].z, tbl[k].waitn, 1'b0, o);
      chk({tag, " tbl_latency"}, o.lat, tbl[k].e_lat);
      chk({tag, " tbl_err"}, o.err, tbl[k].e_err);
      chk({tag, " tbl_alu"}, o.alu3, tbl[k].e_alu);
      chk({tag, " tbl_br_taken"}, o.n_br, tbl[k].e_br);
    end

    // valid held high with other instructions while busy: the add must run unchanged
    run_and_score("hold_add", 32'h00221820, 1'b0, 0, 1'b1, o);
    run_and_score("hold_lw", 32'h8C410004, 1'b0, 2, 1'b1, o);

    // reset in the middle of a load
    i_instr = 32'h8C410004;
    i_instr_valid = 1'b1;
    step();
    i_instr_valid = 1'b0;
    step();
    step();
    chk("pre_rst memread", int'(o_mem_read), 1);
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    chk("post_rst ready", int'(o_instr_ready), 1);
    chk("post_rst strobes", int'({o_alusrc_b, o_reg_write, o_mem_to_reg, o_mem_read,
                                  o_mem_write, o_branch, o_br_taken}), 0);
    chk("post_rst alu", int'(o_alu_control), 0);
    n_done = int'(o_done);
    for (int c = 0; c < 6; c++) begin
      step();
      n_done += int'(o_done);
      n_done += int'(o_mem_read);
    end
    chk("post_rst no_done_no_read", n_done, 0);
    run_and_score("after_rst", 32'h00221822, 1'b0, 0, 1'b0, o);

    for (int r = 0; r < 40; r++) begin
      run_and_score($sformatf("rnd%0d", r), rand_instr(), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 16), 1'($urandom_range(0, 1)), o);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
